// File: rtl/even_issue_ctrl.sv
// Issue/hazard controller for the SPU even pipe.
// Keeps a shadow copy of every in-flight even-pipe instruction (s1..s7).
// It blocks issue on RAW hazards against results that are not ready yet,
// picks forwarding stages for RA/RB/RC, and raises the stage-7 RF write.
module even_issue_ctrl #(
  parameter int REG_ADDR_WD = 7,
  parameter int NUM_STAGES  = 7,
  parameter int CNT_WD      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic [2:0]             iss_lat,
  input  logic                   iss_rt_we,
  input  logic [REG_ADDR_WD-1:0] iss_rt_addr,
  input  logic [REG_ADDR_WD-1:0] iss_ra_addr,
  input  logic [REG_ADDR_WD-1:0] iss_rb_addr,
  input  logic [REG_ADDR_WD-1:0] iss_rc_addr,
  input  logic [2:0]             iss_src_use,
  output logic [2:0]             fwd_sel_ra,
  output logic [2:0]             fwd_sel_rb,
  output logic [2:0]             fwd_sel_rc,
  output logic [NUM_STAGES-1:0]  stg_valid,
  output logic [REG_ADDR_WD-1:0] rf_addr_s2_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s3_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s4_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s5_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s6_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s7_ep,
  output logic                   wb_valid,
  output logic [REG_ADDR_WD-1:0] wb_addr,
  output logic [CNT_WD-1:0]      stall_cnt
);

  typedef struct packed {
    logic       hz;
    logic [2:0] sel;
  } src_chk_t;

  logic [NUM_STAGES:1]    stg_vld;
  logic [REG_ADDR_WD-1:0] stg_addr [1:NUM_STAGES];
  logic [2:0]             stg_lat  [1:NUM_STAGES];

  src_chk_t chk_ra, chk_rb, chk_rc;
  logic     accept;

  // Latencies below 2 are treated as 2: stage 1 can never supply a result.
  function automatic logic [2:0] norm_lat(input logic [2:0] lat);
    return (lat < 3'd2) ? 3'd2 : lat;
  endfunction

  // Saturating increment for the stall counter.
  function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] val);
    return (val == {CNT_WD{1'b1}}) ? val : val + 1'b1;
  endfunction

  // Scan oldest to youngest so the youngest (lowest stage) match wins.
  function automatic src_chk_t src_check(input logic [REG_ADDR_WD-1:0] src,
                                         input logic                   used);
    src_chk_t res;
    res = '0;
    if (used) begin
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (stg_vld[k] && (stg_addr[k] == src)) begin
          if (k >= int'(stg_lat[k])) begin
            res.hz  = 1'b0;
            res.sel = 3'(k);
          end else begin
            res.hz  = 1'b1;
            res.sel = 3'd0;
          end
        end
      end
    end
    return res;
  endfunction

  // Hazard detection and forwarding selects, purely combinational.
  always_comb begin
    chk_ra     = src_check(iss_ra_addr, iss_src_use[0]);
    chk_rb     = src_check(iss_rb_addr, iss_src_use[1]);
    chk_rc     = src_check(iss_rc_addr, iss_src_use[2]);
    iss_ready  = !(chk_ra.hz || chk_rb.hz || chk_rc.hz);
    fwd_sel_ra = chk_ra.sel;
    fwd_sel_rb = chk_rb.sel;
    fwd_sel_rc = chk_rc.sel;
  end

  assign accept = iss_valid && iss_ready && !flush;

  // Shadow pipe: shifts every cycle; flush kills all valids at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
        stg_addr[k] <= '0;
        stg_lat[k]  <= '0;
      end
    end else begin
      stg_vld[1]  <= accept && iss_rt_we;
      stg_addr[1] <= iss_rt_addr;
      stg_lat[1]  <= norm_lat(iss_lat);
      for (int k = 2; k <= NUM_STAGES; k++) begin
        stg_vld[k]  <= stg_vld[k-1] && !flush;
        stg_addr[k] <= stg_addr[k-1];
        stg_lat[k]  <= stg_lat[k-1];
      end
    end
  end

  // Count cycles where a presented instruction is held back by a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (iss_valid && !iss_ready && !flush) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign stg_valid     = stg_vld;
  assign rf_addr_s2_ep = stg_addr[2];
  assign rf_addr_s3_ep = stg_addr[3];
  assign rf_addr_s4_ep = stg_addr[4];
  assign rf_addr_s5_ep = stg_addr[5];
  assign rf_addr_s6_ep = stg_addr[6];
  assign rf_addr_s7_ep = stg_addr[7];
  assign wb_valid      = stg_vld[NUM_STAGES];
  assign wb_addr       = stg_addr[NUM_STAGES];

endmodule

// File: tb/tb_even_issue_ctrl.sv
// Self-checking bench for even_issue_ctrl: table-driven vectors followed by
// hand-written multi-cycle sequences (RAW stall, youngest match, flush,
// asynchronous reset, counter saturation).
module tb_even_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, iss_valid, iss_ready, iss_rt_we;
  logic [2:0] iss_lat, iss_src_use, fwd_sel_ra, fwd_sel_rb, fwd_sel_rc;
  logic [6:0] iss_rt_addr, iss_ra_addr, iss_rb_addr, iss_rc_addr;
  logic [6:0] stg_valid;
  logic [6:0] rf_addr_s2_ep, rf_addr_s3_ep, rf_addr_s4_ep;
  logic [6:0] rf_addr_s5_ep, rf_addr_s6_ep, rf_addr_s7_ep;
  logic       wb_valid;
  logic [6:0] wb_addr;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  even_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_lat(iss_lat),
    .iss_rt_we(iss_rt_we), .iss_rt_addr(iss_rt_addr),
    .iss_ra_addr(iss_ra_addr), .iss_rb_addr(iss_rb_addr), .iss_rc_addr(iss_rc_addr),
    .iss_src_use(iss_src_use),
    .fwd_sel_ra(fwd_sel_ra), .fwd_sel_rb(fwd_sel_rb), .fwd_sel_rc(fwd_sel_rc),
    .stg_valid(stg_valid),
    .rf_addr_s2_ep(rf_addr_s2_ep), .rf_addr_s3_ep(rf_addr_s3_ep),
    .rf_addr_s4_ep(rf_addr_s4_ep), .rf_addr_s5_ep(rf_addr_s5_ep),
    .rf_addr_s6_ep(rf_addr_s6_ep), .rf_addr_s7_ep(rf_addr_s7_ep),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] lat;
    logic       we;
    logic [6:0] rt, ra, rb, rc;
    logic [2:0] src;
    logic       e_rdy;
    logic [2:0] e_fa, e_fb, e_fc;
    logic [6:0] e_stg;
    logic       e_wb;
    logic [6:0] e_wba;
    logic       c3;
    logic [6:0] e_s3;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] lat, input logic we,
                       input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb,
                       input logic [6:0] rc, input logic [2:0] src, input logic fl);
    iss_valid   = v;
    iss_lat     = lat;
    iss_rt_we   = we;
    iss_rt_addr = rt;
    iss_ra_addr = ra;
    iss_rb_addr = rb;
    iss_rc_addr = rc;
    iss_src_use = src;
    flush       = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    repeat (n) cyc();
  endtask

  int  nst;
  bit  got, bad;

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);

    //                v  lat we rt   ra   rb   rc   src     rdy fa fb fc stg         wb wba  c3 s3
    vecs[0]  = '{1'b1, 3'd2, 1'b1, 7'd5, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 3'd0, 3'd0, 3'd0, 7'b0000000, 1'b0, 7'd0, 1'b0, 7'd0};
    vecs[1]  = '{1'b1, 3'd0, 1'b1, 7'd6, 7'd7, 7'd0, 7'd0, 3'b001, 1'b1, 3'd0, 3'd0, 3'd0, 7'b0000001, 1'b0, 7'd0, 1'b0, 7'd0};
    vecs[2]  = '{1'b1, 3'd3, 1'b1, 7'd7, 7'd5, 7'd6, 7'd0, 3'b001, 1'b1, 3'd2, 3'd0, 3'd0, 7'b0000011, 1'b0, 7'd0, 1'b0, 7'd0};
    vecs[3]  = '{1'b1, 3'd2, 1'b0, 7'd0, 7'd7, 7'd0, 7'd0, 3'b001, 1'b0, 3'd0, 3'd0, 3'd0, 7'b0000111, 1'b0, 7'd0, 1'b1, 7'd5};
    vecs[4]  = '{1'b1, 3'd2, 1'b0, 7'd0, 7'd7, 7'd0, 7'd0, 3'b001, 1'b0, 3'd0, 3'd0, 3'd0, 7'b0001110, 1'b0, 7'd0, 1'b1, 7'd6};
    vecs[5]  = '{1'b1, 3'd2, 1'b0, 7'd0, 7'd7, 7'd0, 7'd0, 3'b001, 1'b1, 3'd3, 3'd0, 3'd0, 7'b0011100, 1'b0, 7'd0, 1'b1, 7'd7};
    vecs[6]  = '{1'b0, 3'd2, 1'b0, 7'd0, 7'd0, 7'd6, 7'd7, 3'b110, 1'b1, 3'd0, 3'd5, 3'd4, 7'b0111000, 1'b0, 7'd0, 1'b0, 7'd0};
    vecs[7]  = '{1'b0, 3'd2, 1'b0, 7'd0, 7'd5, 7'd0, 7'd0, 3'b001, 1'b1, 3'd7, 3'd0, 3'd0, 7'b1110000, 1'b1, 7'd5, 1'b0, 7'd0};
    vecs[8]  = '{1'b0, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 3'd0, 3'd0, 3'd0, 7'b1100000, 1'b1, 7'd6, 1'b0, 7'd0};
    vecs[9]  = '{1'b0, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 3'd0, 3'd0, 3'd0, 7'b1000000, 1'b1, 7'd7, 1'b0, 7'd0};
    vecs[10] = '{1'b0, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 3'd0, 3'd0, 3'd0, 7'b0000000, 1'b0, 7'd0, 1'b0, 7'd0};

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 3'd2, 1'b0, 7'd0, 7'd1, 7'd2, 7'd3, 3'b111, 1'b0);
    #1;
    chk("reset stg_valid", 32'(stg_valid), 32'h0);
    chk("reset wb_valid", 32'(wb_valid), 32'h0);
    chk("reset wb_addr", 32'(wb_addr), 32'h0);
    chk("reset rf_addr_s2", 32'(rf_addr_s2_ep), 32'h0);
    chk("reset rf_addr_s7", 32'(rf_addr_s7_ep), 32'h0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'h0);
    chk("reset iss_ready", 32'(iss_ready), 32'h1);
    chk("reset fwd_sel", 32'({fwd_sel_ra, fwd_sel_rb, fwd_sel_rc}), 32'h0);
    idle(1);

    // Table: independent issue, forwarding, short RAW stall, writeback order
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].lat, vecs[i].we, vecs[i].rt, vecs[i].ra,
            vecs[i].rb, vecs[i].rc, vecs[i].src, 1'b0);
      #1;
      chk($sformatf("row%0d iss_ready", i), 32'(iss_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("row%0d fwd_sel_ra", i), 32'(fwd_sel_ra), 32'(vecs[i].e_fa));
      chk($sformatf("row%0d fwd_sel_rb", i), 32'(fwd_sel_rb), 32'(vecs[i].e_fb));
      chk($sformatf("row%0d fwd_sel_rc", i), 32'(fwd_sel_rc), 32'(vecs[i].e_fc));
      chk($sformatf("row%0d stg_valid", i), 32'(stg_valid), 32'(vecs[i].e_stg));
      chk($sformatf("row%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wb));
      if (vecs[i].e_wb) begin
        chk($sformatf("row%0d wb_addr", i), 32'(wb_addr), 32'(vecs[i].e_wba));
        chk($sformatf("row%0d rf_addr_s7", i), 32'(rf_addr_s7_ep), 32'(vecs[i].e_wba));
      end
      if (vecs[i].c3)
        chk($sformatf("row%0d rf_addr_s3", i), 32'(rf_addr_s3_ep), 32'(vecs[i].e_s3));
      cyc();
    end
    chk("table stall_cnt", 32'(stall_cnt), 32'd2);

    // RAW: producer lat 6, dependent consumer right behind it
    drive(1'b1, 3'd6, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b0, 7'd0, 7'd9, 7'd0, 7'd0, 3'b001, 1'b0);
    nst = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (iss_ready) begin got = 1; break; end
      nst++;
      @(posedge clk);
      #1;
    end
    chk("raw released", 32'(got), 32'h1);
    chk("raw stall cycles", 32'(nst), 32'd5);
    chk("raw fwd_sel_ra", 32'(fwd_sel_ra), 32'd6);
    cyc();
    chk("raw stall_cnt", 32'(stall_cnt), 32'd7);
    idle(8);

    // Youngest match wins: lat 2 then lat 7 producer of R3, then RB=3
    drive(1'b1, 3'd2, 1'b1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd7, 1'b1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b0, 7'd0, 7'd0, 7'd3, 7'd0, 3'b010, 1'b0);
    nst = 0; got = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (fwd_sel_rb == 3'd2) bad = 1;
      if (iss_ready) begin got = 1; break; end
      nst++;
      @(posedge clk);
      #1;
    end
    chk("young released", 32'(got), 32'h1);
    chk("young stall cycles", 32'(nst), 32'd6);
    chk("young fwd_sel_rb", 32'(fwd_sel_rb), 32'd7);
    chk("young used older entry", 32'(bad), 32'h0);
    cyc();
    chk("young stall_cnt", 32'(stall_cnt), 32'd13);
    idle(8);

    // Unused source, then flush with four live entries
    drive(1'b1, 3'd7, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b1, 7'd20, 7'd1, 7'd2, 7'd9, 3'b011, 1'b0);
    #1;
    chk("unused rc iss_ready", 32'(iss_ready), 32'h1);
    chk("unused rc fwd_sel_rc", 32'(fwd_sel_rc), 32'h0);
    cyc();
    drive(1'b1, 3'd2, 1'b1, 7'd21, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b1, 7'd22, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b1, 7'd23, 7'd22, 7'd0, 7'd0, 3'b001, 1'b1);
    #1;
    chk("pre-flush stg_valid", 32'(stg_valid), 32'b0001111);
    chk("pre-flush iss_ready", 32'(iss_ready), 32'h0);
    cyc();
    drive(1'b0, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    #1;
    chk("post-flush stg_valid", 32'(stg_valid), 32'h0);
    chk("flush stall_cnt", 32'(stall_cnt), 32'd13);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (wb_valid) bad = 1;
      cyc();
    end
    chk("post-flush wb_valid", 32'(bad), 32'h0);

    // Asynchronous reset with three live entries
    drive(1'b1, 3'd2, 1'b1, 7'd40, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b1, 7'd41, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b1, 7'd42, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b0, 7'd0, 7'd42, 7'd0, 7'd0, 3'b001, 1'b0);
    #1;
    chk("pre-rst stg_valid", 32'(stg_valid), 32'b0000111);
    chk("pre-rst iss_ready", 32'(iss_ready), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid rst stg_valid", 32'(stg_valid), 32'h0);
    chk("mid rst wb_valid", 32'(wb_valid), 32'h0);
    chk("mid rst iss_ready", 32'(iss_ready), 32'h1);
    chk("mid rst fwd_sel_ra", 32'(fwd_sel_ra), 32'h0);
    chk("mid rst stall_cnt", 32'(stall_cnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    chk("after rst stg_valid", 32'(stg_valid), 32'h0);

    // Saturation: producer then six stalled consumer cycles, repeated
    for (int r = 0; r < 11000; r++) begin
      drive(1'b1, 3'd7, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
      cyc();
      drive(1'b1, 3'd2, 1'b0, 7'd0, 7'd9, 7'd0, 7'd0, 3'b001, 1'b0);
      repeat (6) cyc();
    end
    chk("sat stall_cnt", 32'(stall_cnt), 32'hFFFF);
    drive(1'b1, 3'd7, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
    cyc();
    drive(1'b1, 3'd2, 1'b0, 7'd0, 7'd9, 7'd0, 7'd0, 3'b001, 1'b0);
    #1;
    chk("sat stalled", 32'(iss_ready), 32'h0);
    cyc();
    chk("sat hold stall_cnt", 32'(stall_cnt), 32'hFFFF);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
